// File: rtl/hvsync_generator_pkg.sv
// Shared video timing: default raster geometry, derived sync/wrap positions
// and helpers so render and sprite blocks can reuse the same constants.
package hvsync_generator_pkg;

  localparam int POS_W = 9;
  typedef logic [POS_W-1:0] pos_t;

  localparam int H_DISPLAY = 256;
  localparam int H_BACK    = 23;
  localparam int H_FRONT   = 7;
  localparam int H_SYNC    = 23;
  localparam int V_DISPLAY = 240;
  localparam int V_TOP     = 5;
  localparam int V_BOTTOM  = 14;
  localparam int V_SYNC    = 3;

  function automatic int sync_start(input int display, input int trailing_border);
    return display + trailing_border;
  endfunction

  function automatic int sync_end(input int start, input int width);
    return start + width - 1;
  endfunction

  // Last counter value before wrapping; must stay below 2**POS_W.
  function automatic int pos_max(input int display, input int border_a,
                                 input int border_b, input int width);
    return display + border_a + border_b + width - 1;
  endfunction

  localparam int H_SYNC_START = sync_start(H_DISPLAY, H_FRONT);
  localparam int H_SYNC_END   = sync_end(H_SYNC_START, H_SYNC);
  localparam int H_MAX        = pos_max(H_DISPLAY, H_BACK, H_FRONT, H_SYNC);
  localparam int V_SYNC_START = sync_start(V_DISPLAY, V_BOTTOM);
  localparam int V_SYNC_END   = sync_end(V_SYNC_START, V_SYNC);
  localparam int V_MAX        = pos_max(V_DISPLAY, V_TOP, V_BOTTOM, V_SYNC);

endpackage

// File: rtl/hvsync_generator.sv
// Raster scan generator: 9-bit pixel/line counters with registered,
// glitch-free sync pulses and a combinational visible-area flag.
module hvsync_generator #(
  parameter int H_DISPLAY = hvsync_generator_pkg::H_DISPLAY,
  parameter int H_BACK    = hvsync_generator_pkg::H_BACK,
  parameter int H_FRONT   = hvsync_generator_pkg::H_FRONT,
  parameter int H_SYNC    = hvsync_generator_pkg::H_SYNC,
  parameter int V_DISPLAY = hvsync_generator_pkg::V_DISPLAY,
  parameter int V_TOP     = hvsync_generator_pkg::V_TOP,
  parameter int V_BOTTOM  = hvsync_generator_pkg::V_BOTTOM,
  parameter int V_SYNC    = hvsync_generator_pkg::V_SYNC
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [8:0] hpos,
  output logic [8:0] vpos
);
  import hvsync_generator_pkg::*;

  localparam int HS_START_I = sync_start(H_DISPLAY, H_FRONT);
  localparam int VS_START_I = sync_start(V_DISPLAY, V_BOTTOM);

  localparam pos_t HS_START = pos_t'(HS_START_I);
  localparam pos_t HS_END   = pos_t'(sync_end(HS_START_I, H_SYNC));
  localparam pos_t HMAX     = pos_t'(pos_max(H_DISPLAY, H_BACK, H_FRONT, H_SYNC));
  localparam pos_t VS_START = pos_t'(VS_START_I);
  localparam pos_t VS_END   = pos_t'(sync_end(VS_START_I, V_SYNC));
  localparam pos_t VMAX     = pos_t'(pos_max(V_DISPLAY, V_TOP, V_BOTTOM, V_SYNC));
  localparam pos_t HDISP    = pos_t'(H_DISPLAY);
  localparam pos_t VDISP    = pos_t'(V_DISPLAY);

  pos_t hpos_q, hpos_d;
  pos_t vpos_q, vpos_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;

  // Sync flags decode the pre-increment counters so they land one clock late
  // but come straight out of a flop, giving a glitch-free edge downstream.
  always_comb begin
    hpos_d  = hpos_q + pos_t'(1);
    vpos_d  = vpos_q;
    hsync_d = (hpos_q >= HS_START) && (hpos_q <= HS_END);
    vsync_d = (vpos_q >= VS_START) && (vpos_q <= VS_END);
    if (hpos_q == HMAX) begin
      hpos_d = '0;
      if (vpos_q == VMAX) begin
        vpos_d = '0;
      end else begin
        vpos_d = vpos_q + pos_t'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = (hpos_q < HDISP) && (vpos_q < VDISP);

endmodule

// File: tb/tb_hvsync_generator.sv
// Directed bench: default-geometry raster over one full frame plus a shrunken
// geometry instance used to hit async reset while both syncs are active.
module tb_hvsync_generator;

  logic       clk;
  logic       reset;
  logic       hsync, vsync, display_on;
  logic [8:0] hpos, vpos;

  logic       reset_s;
  logic       hsync_s, vsync_s, display_on_s;
  logic [8:0] hpos_s, vpos_s;

  int checks   = 0;
  int failures = 0;

  hvsync_generator dut (
    .clk        (clk),
    .reset      (reset),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos)
  );

  // Small raster: line = 24 clocks (hsync out at hpos 19..22), 13 lines,
  // vsync decoded on lines 10..11.
  hvsync_generator #(
    .H_DISPLAY (16), .H_BACK (2), .H_FRONT (2), .H_SYNC (4),
    .V_DISPLAY (8),  .V_TOP  (1), .V_BOTTOM (2), .V_SYNC (2)
  ) dut_small (
    .clk        (clk),
    .reset      (reset_s),
    .hsync      (hsync_s),
    .vsync      (vsync_s),
    .display_on (display_on_s),
    .hpos       (hpos_s),
    .vpos       (vpos_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  int   eh, ev, peh, pev;
  logic exp_hs, exp_vs, exp_de, prev_hs;
  int   pos_err, hs_err, vs_err, de_err;
  int   vs_cnt, rise_cnt, line0_hs, rise_h;

  initial begin
    reset   = 1'b1;
    reset_s = 1'b1;
    tick(3);
    $display("[TB] reset state");
    check_output("rst_hpos", hpos, 0);
    check_output("rst_vpos", vpos, 0);
    check_output("rst_hsync", hsync, 0);
    check_output("rst_vsync", vsync, 0);
    check_output("rst_display_on", display_on, 1);

    // Small instance: run to (20,10) where both syncs are high, then reset.
    #4 reset_s = 1'b0;
    tick(260);
    check_output("small_hpos", hpos_s, 20);
    check_output("small_vpos", vpos_s, 10);
    check_output("small_hsync", hsync_s, 1);
    check_output("small_vsync", vsync_s, 1);
    check_output("small_display_on", display_on_s, 0);
    #1 reset_s = 1'b1;
    #1;
    check_output("small_async_hpos", hpos_s, 0);
    check_output("small_async_vpos", vpos_s, 0);
    check_output("small_async_hsync", hsync_s, 0);
    check_output("small_async_vsync", vsync_s, 0);
    check_output("small_async_display_on", display_on_s, 1);

    // Main instance: count into line 0, then async reset between edges.
    #3 reset = 1'b0;
    tick(150);
    check_output("mid_hpos", hpos, 150);
    check_output("mid_vpos", vpos, 0);
    #1 reset = 1'b1;
    #1;
    check_output("mid_async_hpos", hpos, 0);
    check_output("mid_async_vpos", vpos, 0);
    check_output("mid_async_display_on", display_on, 1);
    #3 reset = 1'b0;

    // Full frame from (0,0) against an independent position model.
    eh = 0; ev = 0; prev_hs = 1'b0;
    pos_err = 0; hs_err = 0; vs_err = 0; de_err = 0;
    vs_cnt = 0; rise_cnt = 0; line0_hs = 0; rise_h = -1;
    for (int i = 0; i < 80958; i++) begin
      tick(1);
      peh = eh;
      pev = ev;
      if (eh == 308) begin
        eh = 0;
        ev = (ev == 261) ? 0 : ev + 1;
      end else begin
        eh = eh + 1;
      end
      exp_hs = (peh >= 263) && (peh <= 285);
      exp_vs = (pev >= 254) && (pev <= 256);
      exp_de = (eh < 256) && (ev < 240);
      if (hpos !== 9'(eh) || vpos !== 9'(ev)) pos_err++;
      if (hsync !== exp_hs) hs_err++;
      if (vsync !== exp_vs) vs_err++;
      if (display_on !== exp_de) de_err++;
      if (vsync === 1'b1) vs_cnt++;
      if (hsync === 1'b1 && prev_hs === 1'b0) begin
        rise_cnt++;
        if (pev == 0) rise_h = eh;
      end
      if ((ev == 0 || (eh == 0 && ev == 1)) && hsync === 1'b1) line0_hs++;
      prev_hs = hsync;

      if (i == 0) check_output("first_hpos_after_reset", hpos, 1);
      if (eh == 308 && ev == 0) begin
        check_output("wrap_pre_hpos", hpos, 308);
        check_output("wrap_pre_vpos", vpos, 0);
      end
      if (eh == 0 && ev == 1) begin
        check_output("wrap_post_hpos", hpos, 0);
        check_output("wrap_post_vpos", vpos, 1);
      end
      if (eh == 255 && ev == 239) check_output("de_255_239", display_on, 1);
      if (eh == 256 && ev == 0)   check_output("de_256_0", display_on, 0);
      if (eh == 0 && ev == 240)   check_output("de_0_240", display_on, 0);
      if (eh == 308 && ev == 261) check_output("de_308_261", display_on, 0);
    end

    check_output("frame_pos_errors", pos_err, 0);
    check_output("frame_hsync_errors", hs_err, 0);
    check_output("frame_vsync_errors", vs_err, 0);
    check_output("frame_display_on_errors", de_err, 0);
    check_output("line0_hsync_width", line0_hs, 23);
    check_output("line0_hsync_rise_hpos", rise_h, 264);
    check_output("frame_vsync_clocks", vs_cnt, 927);
    check_output("frame_hsync_rises", rise_cnt, 262);
    check_output("frame_end_hpos", hpos, 0);
    check_output("frame_end_vpos", vpos, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
